// File: rtl/mdu_result_select_pkg.sv
// Shared definitions for the MIPS R-type writeback result selector.
// Optional MTHI/MTLO support is enabled by defining MTHI_MTLO_EN.
package mdu_result_select_pkg;

  localparam int unsigned WIDTH_DEF   = 32;
  localparam int unsigned FUNCT_W_DEF = 6;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic {
    ST_IDLE,
    ST_MD_WAIT
  } state_e;

  typedef enum logic [2:0] {
    SRC_ZERO,
    SRC_ALU,
    SRC_SHIFT,
    SRC_HI,
    SRC_LO
  } src_e;

  typedef struct packed {
    src_e src;
    logic we;
    logic illegal;
    logic is_md;
    logic is_div;
    logic mthi;
    logic mtlo;
  } dec_t;

  // Map a funct code onto result source, write enable and sequencing flags.
  function automatic dec_t decode_funct(input logic [5:0] f);
    dec_t d;
    d     = '0;
    d.src = SRC_ZERO;
    case (f)
      F_ADD, F_SUB, F_AND, F_OR, F_SLT: begin
        d.src = SRC_ALU;
        d.we  = 1'b1;
      end
      F_SRL: begin
        d.src = SRC_SHIFT;
        d.we  = 1'b1;
      end
      F_MFHI: begin
        d.src = SRC_HI;
        d.we  = 1'b1;
      end
      F_MFLO: begin
        d.src = SRC_LO;
        d.we  = 1'b1;
      end
      F_MULTU: d.is_md = 1'b1;
      F_DIVU: begin
        d.is_md  = 1'b1;
        d.is_div = 1'b1;
      end
`ifdef MTHI_MTLO_EN
      F_MTHI: d.mthi = 1'b1;
      F_MTLO: d.mtlo = 1'b1;
`endif
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mdu_hilo_regs.sv
// HI/LO storage; mul/div completion has priority over MTHI/MTLO writes.
module mdu_hilo_regs
  import mdu_result_select_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             md_we,
  input  logic [WIDTH-1:0] md_hi,
  input  logic [WIDTH-1:0] md_lo,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] hi_q,
  output logic [WIDTH-1:0] lo_q
);

  // HI/LO update from mul/div results or direct moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (md_we) begin
      hi_q <= md_hi;
      lo_q <= md_lo;
    end else begin
      if (hi_we) hi_q <= wr_data;
      if (lo_we) lo_q <= wr_data;
    end
  end

endmodule

// File: rtl/mdu_result_select.sv
// Registered, handshaked writeback result selector with HI/LO and
// multi-cycle MULTU/DIVU sequencing. MTHI_MTLO_EN enables MTHI/MTLO.
module mdu_result_select
  import mdu_result_select_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned FUNCT_W = FUNCT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FUNCT_W-1:0] in_funct,
  input  logic [WIDTH-1:0]   alu_out,
  input  logic [WIDTH-1:0]   shift_out,
  input  logic [WIDTH-1:0]   rs_data,
  output logic               md_start,
  output logic               md_div,
  input  logic               md_done,
  input  logic [WIDTH-1:0]   md_hi,
  input  logic [WIDTH-1:0]   md_lo,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_we,
  output logic               out_illegal,
  output logic [WIDTH-1:0]   hi_q,
  output logic [WIDTH-1:0]   lo_q
);

  state_e           state;
  dec_t             dec;
  logic [WIDTH-1:0] sel_data;
  logic             accept;
  logic             md_we;
  logic             hi_we;
  logic             lo_we;

  // Decode the offered funct code.
  always_comb begin
    dec = decode_funct(6'(in_funct));
  end

  // Select the result source for non-mul/div ops.
  always_comb begin
    sel_data = '0;
    case (dec.src)
      SRC_ALU:   sel_data = alu_out;
      SRC_SHIFT: sel_data = shift_out;
      SRC_HI:    sel_data = hi_q;
      SRC_LO:    sel_data = lo_q;
      default:   sel_data = '0;
    endcase
  end

  // Issue is allowed only in IDLE with the output slot free or draining.
  always_comb begin
    in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
    accept   = in_valid && in_ready;
    md_we    = (state == ST_MD_WAIT) && md_done;
    hi_we    = accept && dec.mthi;
    lo_we    = accept && dec.mtlo;
  end

  // Control FSM with registered output slot and mul/div launch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_we      <= 1'b0;
      out_illegal <= 1'b0;
      md_start    <= 1'b0;
      md_div      <= 1'b0;
    end else begin
      md_start <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (dec.is_md) begin
              md_start <= 1'b1;
              md_div   <= dec.is_div;
              state    <= ST_MD_WAIT;
            end else begin
              out_valid   <= 1'b1;
              out_data    <= sel_data;
              out_we      <= dec.we;
              out_illegal <= dec.illegal;
            end
          end
        end
        ST_MD_WAIT: begin
          if (md_done) begin
            out_valid   <= 1'b1;
            out_data    <= '0;
            out_we      <= 1'b0;
            out_illegal <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  mdu_hilo_regs #(
    .WIDTH(WIDTH)
  ) u_hilo (
    .clk    (clk),
    .rst_n  (rst_n),
    .md_we  (md_we),
    .md_hi  (md_hi),
    .md_lo  (md_lo),
    .hi_we  (hi_we),
    .lo_we  (lo_we),
    .wr_data(rs_data),
    .hi_q   (hi_q),
    .lo_q   (lo_q)
  );

endmodule

// File: tb/tb_mdu_result_select.sv
// Scoreboard bench for mdu_result_select.
module tb_mdu_result_select;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [5:0]   in_funct;
  logic [W-1:0] alu_out, shift_out, rs_data;
  logic         md_start, md_div, md_done;
  logic [W-1:0] md_hi, md_lo;
  logic         out_valid, out_ready;
  logic [W-1:0] out_data;
  logic         out_we, out_illegal;
  logic [W-1:0] hi_q, lo_q;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [W+1:0] exp_q[$];
  logic [W+1:0] exp_v;
  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;

  mdu_result_select dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_funct(in_funct), .alu_out(alu_out), .shift_out(shift_out),
    .rs_data(rs_data), .md_start(md_start), .md_div(md_div),
    .md_done(md_done), .md_hi(md_hi), .md_lo(md_lo),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_we(out_we), .out_illegal(out_illegal), .hi_q(hi_q), .lo_q(lo_q)
  );

  always #5 clk = ~clk;

  // Offer one instruction and hold it until accepted (bounded).
  task automatic issue(input logic [5:0] f, input logic [W-1:0] a,
                       input logic [W-1:0] s, input logic [W-1:0] r);
    int n;
    n = 0;
    in_valid = 1'b1; in_funct = f; alu_out = a; shift_out = s; rs_data = r;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      $display("FAIL issue_timeout funct=%b in_ready=%b required 1", f, in_ready);
      $fatal(1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    total_cnt++;
    if ({out_valid, out_data, out_we, out_illegal, md_start, md_div} !== '0 ||
        hi_q !== '0 || lo_q !== '0) begin
      $display("FAIL reset_state got v=%b d=%h we=%b il=%b st=%b dv=%b hi=%h lo=%h required all 0",
               out_valid, out_data, out_we, out_illegal, md_start, md_div, hi_q, lo_q);
    end else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b required 1", in_ready);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_add;
    out_ready = 1'b1;
    exp_q.push_back({32'h5, 1'b1, 1'b0});
    issue(6'b100000, 32'h5, 32'h0, 32'h0);
    @(negedge clk);
    exp_v = exp_q.pop_front();
    total_cnt++;
    if (out_valid !== 1'b1 || {out_data, out_we, out_illegal} !== exp_v)
      $display("FAIL add_result got v=%b %h/%b/%b required v=1 %h", out_valid,
               out_data, out_we, out_illegal, exp_v);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_multu;
    issue(6'b011001, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    total_cnt++;
    if (md_start !== 1'b1 || md_div !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL multu_start got st=%b dv=%b rdy=%b v=%b required 1/0/0/0",
               md_start, md_div, in_ready, out_valid);
    else pass_cnt++;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      if (i == 3) begin
        md_done = 1'b1; md_hi = 32'h1; md_lo = 32'hFFFF_FFFE;
        model_hi = 32'h1; model_lo = 32'hFFFF_FFFE;
        exp_q.push_back({32'h0, 1'b0, 1'b0});
      end
      @(negedge clk);
      total_cnt++;
      if (in_ready !== 1'b0 || md_start !== 1'b0 || out_valid !== 1'b0)
        $display("FAIL multu_wait%0d got rdy=%b st=%b v=%b required 0/0/0",
                 i, in_ready, md_start, out_valid);
      else pass_cnt++;
    end
    @(posedge clk); #1;
    md_done = 1'b0;
    @(negedge clk);
    exp_v = exp_q.pop_front();
    total_cnt++;
    if (out_valid !== 1'b1 || {out_data, out_we, out_illegal} !== exp_v ||
        hi_q !== model_hi || lo_q !== model_lo)
      $display("FAIL multu_done got v=%b %h/%b/%b hi=%h lo=%h required v=1 %h hi=%h lo=%h",
               out_valid, out_data, out_we, out_illegal, hi_q, lo_q, exp_v, model_hi, model_lo);
    else pass_cnt++;
    exp_q.push_back({model_hi, 1'b1, 1'b0});
    issue(6'b010000, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    exp_v = exp_q.pop_front();
    total_cnt++;
    if (out_valid !== 1'b1 || {out_data, out_we, out_illegal} !== exp_v)
      $display("FAIL mfhi_result got v=%b %h/%b/%b required v=1 %h", out_valid,
               out_data, out_we, out_illegal, exp_v);
    else pass_cnt++;
    exp_q.push_back({model_lo, 1'b1, 1'b0});
    issue(6'b010010, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    exp_v = exp_q.pop_front();
    total_cnt++;
    if (out_valid !== 1'b1 || {out_data, out_we, out_illegal} !== exp_v)
      $display("FAIL mflo_result got v=%b %h/%b/%b required v=1 %h", out_valid,
               out_data, out_we, out_illegal, exp_v);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_srl_stall;
    out_ready = 1'b0;
    exp_q.push_back({32'h8, 1'b1, 1'b0});
    issue(6'b000010, 32'h0, 32'h8, 32'h0);
    in_valid = 1'b1; in_funct = 6'b100000; alu_out = 32'h77;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total_cnt++;
      if (out_valid !== 1'b1 || out_data !== 32'h8 || out_we !== 1'b1 || in_ready !== 1'b0)
        $display("FAIL srl_hold%0d got v=%b d=%h we=%b rdy=%b required 1/8/1/0",
                 i, out_valid, out_data, out_we, in_ready);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    exp_v = exp_q.pop_front();
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || {out_data, out_we, out_illegal} !== exp_v)
      $display("FAIL srl_release got rdy=%b v=%b %h/%b/%b required rdy=1 v=1 %h",
               in_ready, out_valid, out_data, out_we, out_illegal, exp_v);
    else pass_cnt++;
    exp_q.push_back({32'h77, 1'b1, 1'b0});
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    exp_v = exp_q.pop_front();
    total_cnt++;
    if (out_valid !== 1'b1 || {out_data, out_we, out_illegal} !== exp_v)
      $display("FAIL srl_next got v=%b %h/%b/%b required v=1 %h", out_valid,
               out_data, out_we, out_illegal, exp_v);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_illegal;
    exp_q.push_back({32'h0, 1'b0, 1'b1});
    issue(6'b111111, 32'h1234, 32'h5678, 32'h0);
    @(negedge clk);
    exp_v = exp_q.pop_front();
    total_cnt++;
    if (out_valid !== 1'b1 || {out_data, out_we, out_illegal} !== exp_v)
      $display("FAIL illegal_result got v=%b %h/%b/%b required v=1 %h", out_valid,
               out_data, out_we, out_illegal, exp_v);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_mtlo;
`ifdef MTHI_MTLO_EN
    exp_q.push_back({32'h0, 1'b0, 1'b0});
    model_lo = 32'hDEAD_BEEF;
`else
    exp_q.push_back({32'h0, 1'b0, 1'b1});
`endif
    issue(6'b010011, 32'h0, 32'h0, 32'hDEAD_BEEF);
    @(negedge clk);
    exp_v = exp_q.pop_front();
    total_cnt++;
    if (out_valid !== 1'b1 || {out_data, out_we, out_illegal} !== exp_v)
      $display("FAIL mtlo_result got v=%b %h/%b/%b required v=1 %h", out_valid,
               out_data, out_we, out_illegal, exp_v);
    else pass_cnt++;
    exp_q.push_back({model_lo, 1'b1, 1'b0});
    issue(6'b010010, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    exp_v = exp_q.pop_front();
    total_cnt++;
    if (out_valid !== 1'b1 || {out_data, out_we, out_illegal} !== exp_v)
      $display("FAIL mtlo_mflo got v=%b %h/%b/%b required v=1 %h", out_valid,
               out_data, out_we, out_illegal, exp_v);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [5:0]   f[5];
    logic [W-1:0] a[5];
    logic [W+1:0] e[5];
    f[0] = 6'b100000; a[0] = 32'h11;  e[0] = {32'h11, 1'b1, 1'b0};
    f[1] = 6'b100010; a[1] = 32'h22;  e[1] = {32'h22, 1'b1, 1'b0};
    f[2] = 6'b100101; a[2] = 32'h33;  e[2] = {32'h33, 1'b1, 1'b0};
    f[3] = 6'b000010; a[3] = 32'h0;   e[3] = {32'h44, 1'b1, 1'b0};
    f[4] = 6'b010010; a[4] = 32'h0;   e[4] = {model_lo, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_funct = f[i]; alu_out = a[i]; shift_out = 32'h44;
      exp_q.push_back(e[i]);
      @(negedge clk);
      total_cnt++;
      if (in_ready !== 1'b1) $display("FAIL b2b_ready%0d got %b required 1", i, in_ready);
      else pass_cnt++;
      if (i > 0) begin
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (out_valid !== 1'b1 || {out_data, out_we, out_illegal} !== exp_v)
          $display("FAIL b2b_result%0d got v=%b %h/%b/%b required v=1 %h", i - 1,
                   out_valid, out_data, out_we, out_illegal, exp_v);
        else pass_cnt++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    exp_v = exp_q.pop_front();
    total_cnt++;
    if (out_valid !== 1'b1 || {out_data, out_we, out_illegal} !== exp_v)
      $display("FAIL b2b_result4 got v=%b %h/%b/%b required v=1 %h",
               out_valid, out_data, out_we, out_illegal, exp_v);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_md_wait;
    issue(6'b011011, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    total_cnt++;
    if (md_start !== 1'b1 || md_div !== 1'b1)
      $display("FAIL divu_start got st=%b dv=%b required 1/1", md_start, md_div);
    else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b0;
    model_hi = '0; model_lo = '0;
    @(negedge clk);
    total_cnt++;
    if (out_valid !== 1'b0 || md_div !== 1'b0 || hi_q !== '0 || lo_q !== '0 || in_ready !== 1'b1)
      $display("FAIL reset_in_wait got v=%b dv=%b hi=%h lo=%h rdy=%b required 0/0/0/0/1",
               out_valid, md_div, hi_q, lo_q, in_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    md_done = 1'b1; md_hi = 32'hAAAA_AAAA; md_lo = 32'h5555_5555;
    @(posedge clk); #1;
    md_done = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (out_valid !== 1'b0 || hi_q !== model_hi || lo_q !== model_lo)
      $display("FAIL late_done got v=%b hi=%h lo=%h required v=0 hi=%h lo=%h",
               out_valid, hi_q, lo_q, model_hi, model_lo);
    else pass_cnt++;
  endtask

  initial begin
    in_valid = 1'b0; in_funct = '0; alu_out = '0; shift_out = '0; rs_data = '0;
    md_done = 1'b0; md_hi = '0; md_lo = '0; out_ready = 1'b1;
    test_reset;
    test_add;
    test_multu;
    test_srl_stall;
    test_illegal;
    test_mtlo;
    test_back_to_back;
    test_reset_md_wait;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mdu_result_select.md
# mdu_result_select

Registered, handshaked writeback result selector for the MIPS R-type datapath; the successor of the combinational funct-decoded result mux. Selects among ALU, shifter and HI/LO sources by funct code. Owns the HI/LO registers and sequences multi-cycle MULTU/DIVU through an external multiply/divide unit, stalling issue until completion. Sits between the execute units and register-file writeback.

## Interface
Parameters:
- WIDTH, 32, datapath width of all data ports and HI/LO
- FUNCT_W, 6, funct field width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction offered
- in_ready  out  1  instruction accepted when in_valid && in_ready
- in_funct  in  FUNCT_W  R-type funct code
- alu_out  in  WIDTH  ALU result
- shift_out  in  WIDTH  shifter result
- rs_data  in  WIDTH  rs operand (MTHI/MTLO only)
- md_start  out  1  one-cycle pulse launching the mul/div unit
- md_div  out  1  1 = DIVU, 0 = MULTU; valid with md_start
- md_done  in  1  mul/div completion pulse
- md_hi, md_lo  in  WIDTH  mul/div results; valid with md_done
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result when out_valid && out_ready
- out_data  out  WIDTH  selected result
- out_we  out  1  register-file write enable for this result
- out_illegal  out  1  funct not recognised
- hi_q, lo_q  out  WIDTH  current HI/LO contents

## Operation
- Funct map: AND 100100, OR 100101, ADD 100000, SUB 100010, SLT 101010 -> alu_out, we=1; SRL 000010 -> shift_out, we=1; MFHI 010000 -> hi_q, we=1; MFLO 010010 -> lo_q, we=1; MULTU 011001, DIVU 011011 -> mul/div sequence, we=0; anything else -> data 0, we=0, illegal=1.
- States: IDLE, MD_WAIT.
- IDLE: in_ready = !out_valid || out_ready. On accept of non-mul/div op, output register loads data/we/illegal, out_valid=1. On accept of MULTU/DIVU: md_start=1 one cycle, md_div set, go MD_WAIT.
- MD_WAIT: in_ready=0. On md_done: HI<=md_hi, LO<=md_lo, output register loads data 0, we=0, illegal=0, out_valid=1; go IDLE.
- md_done in IDLE ignored.
- out_valid with !out_ready: out_data/we/illegal held stable; no new accept.
- Reset (any time, including MD_WAIT): state IDLE, HI=LO=0, out_valid=0, out_data=0, out_we=0, out_illegal=0, md_start=0, md_div=0. in_ready=1 while in reset-released IDLE.

## Timing
- ALU/shift/MF ops: out_valid 1 cycle after accept.
- MULTU/DIVU: md_start in the cycle after accept; out_valid and new hi_q/lo_q in the cycle after md_done. md_done in same cycle as md_start is legal and completes.
- MFHI accepted after a MULTU sees updated HI (issue is blocked until HI writes).
- Back-to-back: with out_ready=1 held, one op accepted per cycle.

## Configuration
- MTHI_MTLO_EN defined: MTHI 010001 writes HI<=rs_data, MTLO 010011 writes LO<=rs_data, registered on accept; result out_valid next cycle, data 0, we=0, illegal=0.
- Undefined: those codes decode as illegal; rs_data unused.

## Structure
- Shared package: funct code constants, state enum, WIDTH default.
- One sub-module: mdu_hilo_regs (HI/LO storage, async reset, write from md results or MTHI/MTLO).

## Test plan
- Reset, then ADD with alu_out=0x0000_0005, out_ready=1 -> next cycle out_valid=1, out_data=5, out_we=1.
- MULTU, md_done 3 cycles after md_start with md_hi=0x1, md_lo=0xFFFF_FFFE; then MFHI, MFLO -> out_data 0x1 then 0xFFFF_FFFE; in_ready=0 throughout MD_WAIT.
- SRL shift_out=0x8 with out_ready=0 for 4 cycles -> out_data=0x8 held, in_ready=0; released the cycle out_ready rises.
- funct 111111 -> out_data=0, out_we=0, out_illegal=1.
- rst_n low during MD_WAIT, then late md_done -> ignored, HI=LO=0, out_valid=0.
- With MTHI_MTLO_EN: MTLO rs_data=0xDEAD_BEEF then MFLO -> out_data=0xDEAD_BEEF; without: MTLO -> out_illegal=1.
